// File: rtl/ir_align_queue.sv
// ir_align_queue: 32-byte instruction byte queue feeding decode.
// Accepts 16-byte fetch lines (with a leading-byte offset), presents a
// 16-byte byte-aligned window with the current instruction in the top
// byte, and retires a variable number of bytes per decoded instruction.
// Queue byte k lives at buf_r[255-8k -: 8], so byte 0 is the MSB byte.

module ir_align_queue (
    input  logic         clk,
    input  logic         reset,
    input  logic         fill_valid,
    input  logic [127:0] fill_line,
    input  logic [3:0]   fill_offset,
    output logic         fill_ready,
    input  logic         flush,
    input  logic [31:0]  flush_eip,
    output logic [127:0] ir,
    output logic         ir_valid,
    output logic [31:0]  ir_eip,
    input  logic         dec_accept,
    input  logic [3:0]   dec_len
);

    logic [255:0] buf_r;
    logic [5:0]   count_r;
    logic [31:0]  eip_r;

    logic         consume_s;
    logic [5:0]   len_s;
    logic         fill_s;
    logic [5:0]   n_s;
    logic [5:0]   base_s;
    logic [255:0] shifted_s;
    logic [255:0] line_ext_s;
    logic [255:0] keep_mask_s;
    logic [255:0] buf_next_s;
    logic [5:0]   count_next_s;
    logic [31:0]  eip_next_s;

    // Outputs are straight slices/compares of registered state; no path from dec_accept.
    assign ir         = buf_r[255:128];
    assign ir_valid   = (count_r >= 6'd16);
    assign fill_ready = (count_r <= 6'd16);
    assign ir_eip     = eip_r;

    // Next-state: shift out consumed bytes, then append the fill behind the survivors.
    always_comb begin
        consume_s = ir_valid & dec_accept;
        if (consume_s) begin
            len_s = {2'b00, dec_len};
        end else begin
            len_s = 6'd0;
        end
        fill_s = fill_valid & fill_ready & ~flush;
        n_s    = 6'd16 - {2'b00, fill_offset};
        // Write position is measured after the consume shift.
        base_s    = count_r - len_s;
        shifted_s = buf_r << {len_s, 3'b000};
        // Drop the bytes below fill_offset, then slide the line down to base_s.
        line_ext_s  = {fill_line << {fill_offset, 3'b000}, 128'd0} >> {base_s, 3'b000};
        // Keep only the surviving bytes 0..base_s-1; everything above is overwritten.
        keep_mask_s = ~({256{1'b1}} >> {base_s, 3'b000});

        if (flush) begin
            buf_next_s   = buf_r;
            count_next_s = 6'd0;
            eip_next_s   = flush_eip;
        end else if (fill_s) begin
            buf_next_s   = (shifted_s & keep_mask_s) | line_ext_s;
            count_next_s = base_s + n_s;
            eip_next_s   = eip_r + {26'd0, len_s};
        end else begin
            buf_next_s   = shifted_s;
            count_next_s = base_s;
            eip_next_s   = eip_r + {26'd0, len_s};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_r   <= 256'd0;
            count_r <= 6'd0;
            eip_r   <= 32'd0;
        end else begin
            buf_r   <= buf_next_s;
            count_r <= count_next_s;
            eip_r   <= eip_next_s;
        end
    end

endmodule

// File: tb/tb_ir_align_queue.sv
// Directed self-checking bench for ir_align_queue.
`timescale 1ns/1ps

module tb_ir_align_queue;

    logic         clk;
    logic         reset;
    logic         fill_valid;
    logic [127:0] fill_line;
    logic [3:0]   fill_offset;
    logic         fill_ready;
    logic         flush;
    logic [31:0]  flush_eip;
    logic [127:0] ir;
    logic         ir_valid;
    logic [31:0]  ir_eip;
    logic         dec_accept;
    logic [3:0]   dec_len;

    int checks = 0;
    int errors = 0;

    ir_align_queue dut (
        .clk         (clk),
        .reset       (reset),
        .fill_valid  (fill_valid),
        .fill_line   (fill_line),
        .fill_offset (fill_offset),
        .fill_ready  (fill_ready),
        .flush       (flush),
        .flush_eip   (flush_eip),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_eip      (ir_eip),
        .dec_accept  (dec_accept),
        .dec_len     (dec_len)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Line holding bytes first, first+1, ... first+15 (byte 0 at the top).
    function automatic logic [127:0] mk_line(input logic [7:0] first);
        logic [127:0] l;
        l = 128'd0;
        for (int k = 0; k < 16; k++) begin
            l[127-8*k -: 8] = first + 8'(k);
        end
        return l;
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        fill_valid  = 1'b0;
        fill_line   = 128'd0;
        fill_offset = 4'd0;
        flush       = 1'b0;
        flush_eip   = 32'd0;
        dec_accept  = 1'b0;
        dec_len     = 4'd0;
        #11;
        check_val("rst_ir",       ir, 128'd0);
        check_val("rst_valid",    {127'd0, ir_valid}, 128'd0);
        check_val("rst_eip",      {96'd0, ir_eip}, 128'd0);
        check_val("rst_ready",    {127'd0, fill_ready}, 128'd1);
        #1;
        reset = 1'b0;

        // 1. two fills
        fill_valid = 1'b1; fill_line = mk_line(8'h00); fill_offset = 4'd0;
        step();
        check_val("t1_count_a",   {122'd0, dut.count_r}, 128'd16);
        check_val("t1_valid_a",   {127'd0, ir_valid}, 128'd1);
        check_val("t1_ir_a",      ir, 128'h000102030405060708090A0B0C0D0E0F);
        fill_line = mk_line(8'h10);
        step();
        fill_valid = 1'b0;
        check_val("t1_count_b",   {122'd0, dut.count_r}, 128'd32);
        check_val("t1_ready_b",   {127'd0, fill_ready}, 128'd0);

        // 2. consume 3, then backpressure
        dec_accept = 1'b1; dec_len = 4'd3;
        step();
        dec_accept = 1'b0;
        check_val("t2_ir",        ir, 128'h030405060708090A0B0C0D0E0F101112);
        check_val("t2_eip",       {96'd0, ir_eip}, 128'd3);
        check_val("t2_count",     {122'd0, dut.count_r}, 128'd29);
        check_val("t2_ready",     {127'd0, fill_ready}, 128'd0);
        fill_valid = 1'b1; fill_line = mk_line(8'hA0);
        step();
        fill_valid = 1'b0;
        check_val("t2_bp_count",  {122'd0, dut.count_r}, 128'd29);

        // 3. simultaneous consume and fill from count 16
        flush = 1'b1; flush_eip = 32'd0;
        step();
        flush = 1'b0;
        fill_valid = 1'b1; fill_line = mk_line(8'h00); fill_offset = 4'd0;
        step();
        check_val("t3_pre_count", {122'd0, dut.count_r}, 128'd16);
        fill_line = mk_line(8'h20); dec_accept = 1'b1; dec_len = 4'd5;
        step();
        fill_valid = 1'b0; dec_accept = 1'b0;
        check_val("t3_count",     {122'd0, dut.count_r}, 128'd27);
        check_val("t3_ir",        ir, 128'h05060708090A0B0C0D0E0F2021222324);

        // 4. flush with offset; same-cycle fill and consume ignored
        flush = 1'b1; flush_eip = 32'h0000_100A;
        fill_valid = 1'b1; fill_line = mk_line(8'hB0); fill_offset = 4'd0;
        dec_accept = 1'b1; dec_len = 4'd3;
        step();
        flush = 1'b0; fill_valid = 1'b0; dec_accept = 1'b0;
        check_val("t4_valid",     {127'd0, ir_valid}, 128'd0);
        check_val("t4_eip",       {96'd0, ir_eip}, 128'h100A);
        check_val("t4_count",     {122'd0, dut.count_r}, 128'd0);
        check_val("t4_ready",     {127'd0, fill_ready}, 128'd1);
        fill_valid = 1'b1; fill_line = mk_line(8'h40); fill_offset = 4'd10;
        step();
        check_val("t4_count6",    {122'd0, dut.count_r}, 128'd6);
        check_val("t4_valid6",    {127'd0, ir_valid}, 128'd0);
        fill_line = mk_line(8'h50); fill_offset = 4'd0;
        step();
        fill_valid = 1'b0;
        check_val("t4_count22",   {122'd0, dut.count_r}, 128'd22);
        check_val("t4_ir",        ir, 128'h4A4B4C4D4E4F50515253545556575859);

        // 5. eip wrap and zero-length consume
        flush = 1'b1; flush_eip = 32'hFFFF_FFFE;
        step();
        flush = 1'b0;
        fill_valid = 1'b1; fill_line = mk_line(8'h60); fill_offset = 4'd14;
        step();
        check_val("t5_count2",    {122'd0, dut.count_r}, 128'd2);
        fill_line = mk_line(8'h70); fill_offset = 4'd0;
        step();
        fill_valid = 1'b0;
        check_val("t5_count18",   {122'd0, dut.count_r}, 128'd18);
        dec_accept = 1'b1; dec_len = 4'd0;
        step();
        check_val("t5_z_count",   {122'd0, dut.count_r}, 128'd18);
        check_val("t5_z_eip",     {96'd0, ir_eip}, 128'hFFFF_FFFE);
        check_val("t5_z_ir",      ir, 128'h6E6F707172737475767778797A7B7C7D);
        dec_len = 4'd4;
        step();
        dec_accept = 1'b0;
        check_val("t5_wrap_eip",  {96'd0, ir_eip}, 128'd2);
        check_val("t5_count14",   {122'd0, dut.count_r}, 128'd14);

        // 6. asynchronous reset with count 24
        flush = 1'b1; flush_eip = 32'h0000_0008;
        step();
        flush = 1'b0;
        fill_valid = 1'b1; fill_line = mk_line(8'h80); fill_offset = 4'd8;
        step();
        fill_line = mk_line(8'h90); fill_offset = 4'd0;
        step();
        fill_valid = 1'b0;
        check_val("t6_count24",   {122'd0, dut.count_r}, 128'd24);
        check_val("t6_eip_pre",   {96'd0, ir_eip}, 128'd8);
        #3;
        reset = 1'b1;
        #1;
        check_val("t6_valid",     {127'd0, ir_valid}, 128'd0);
        check_val("t6_count",     {122'd0, dut.count_r}, 128'd0);
        check_val("t6_eip",       {96'd0, ir_eip}, 128'd0);
        check_val("t6_ready",     {127'd0, fill_ready}, 128'd1);
        check_val("t6_ir",        ir, 128'd0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_align_queue.md
# ir_align_queue

Instruction byte queue that feeds the decode stage. It accepts 16-byte fetch lines, stores up to 32 bytes, and presents a 128-bit byte-aligned instruction window `ir` with the current instruction's first byte in the top byte. Decode consumes a variable number of bytes per instruction. It is the producer side of the `IR` window that the immediate, displacement and opcode extractors read from.

## Interface
Parameters: none. The geometry is fixed at a 16-byte window, 16-byte fill lines and 32-byte storage.

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `fill_valid`  in  1  fetch presents a line
- `fill_line`  in  128  fetch line; byte k at bits [127-8k : 120-8k]
- `fill_offset`  in  4  first useful byte of `fill_line` (0..15); bytes below it are discarded
- `fill_ready`  out  1  queue can accept a line this cycle
- `flush`  in  1  redirect; empties the queue
- `flush_eip`  in  32  linear address of the first byte after the redirect
- `ir`  out  128  window; queue byte k at bits [127-8k : 120-8k]
- `ir_valid`  out  1  window holds 16 valid bytes
- `ir_eip`  out  32  address of `ir` byte 0
- `dec_accept`  in  1  decode consumes the current instruction
- `dec_len`  in  4  instruction length in bytes (1..15); 0 consumes nothing

## Operation
State:
- `buf`: 32 bytes
- `count`: 6 bits, range 0..32
- `eip`: 32 bits

Outputs:
- `ir` = `buf` bytes 0..15, driven combinationally from registers.
- `ir_valid` = (`count` >= 16).
- `ir_eip` = `eip`.
- `fill_ready` = (`count` <= 16). It depends only on registered state, never on `dec_accept`.

Per cycle, define:
- `c` = `ir_valid` & `dec_accept`
- `L` = `c` ? `dec_len` : 0
- `f` = `fill_valid` & `fill_ready` & !`flush`
- `n` = 16 - `fill_offset`

Next-state rules:
- **Flush:** `flush` = 1 gives `count` = 0 and `eip` = `flush_eip`. Any fill and any consume in the same cycle are ignored. `buf` contents are don't-care but retain their value.
- **Consume:** `buf` shifts toward byte 0 by `L` bytes. `count` decreases by `L`. `eip` increases by `L` modulo 2^32, with no flag on wrap.
- **Fill:** bytes `fill_offset`..15 of `fill_line` are written to `buf` positions (`count` - `L`) .. (`count` - `L` + `n` - 1). The write position is computed after the shift, so a simultaneous consume and fill are both honoured. `count` increases by `n`.
- **Bounds:** `count` - `L` + `n` <= 32 always holds, because `fill_ready` guarantees `count` <= 16. Positions at or above `count` are don't-care.
- **Illegal lengths:** `dec_len` = 0 with `c` = 1 is a no-op. `dec_accept` while `ir_valid` = 0 is ignored.

Reset values: `count` = 0, `eip` = 0, `buf` = all zero. Therefore `ir` = 0, `ir_valid` = 0, `ir_eip` = 0 and `fill_ready` = 1.

## Timing
- **Fill latency:** a line accepted at edge N is visible in `ir` after edge N. If the resulting `count` >= 16, `ir_valid` = 1 in cycle N+1.
- **Consume latency:** a consume at edge N presents the next instruction at `ir` byte 0, with `ir_eip` updated, in cycle N+1. Back-to-back consumes every cycle are supported while `count` stays >= 16.
- **Handshake:** a fill transfers on the edge where `fill_valid` & `fill_ready` = 1. Fetch holds `fill_line` and `fill_offset` while `fill_ready` = 0.
- **Flush timing:**
  - After a flush at edge N: `ir_valid` = 0 and `fill_ready` = 1 in cycle N+1.
  - The first post-flush line uses `fill_offset` = `flush_eip`[3:0]; later lines use 0.
- **Reset:** asserting `reset` mid-operation clears state immediately, without waiting for a clock edge. Deassertion is followed by normal operation on the next edge.
- **No bypass:** a fill never makes `ir_valid` rise in the same cycle it is accepted.

## Test plan
1. **Reset, then two fills.** Reset, then fill line A (bytes 00..0F, offset 0) and line B (bytes 10..1F, offset 0).
   - After A: `count` = 16, `ir_valid` = 1, `ir` = 000102…0F.
   - After B: `count` = 32, `fill_ready` = 0.
2. **Consume, then backpressure.** From test 1 state, `dec_len` = 3 with accept.
   - `ir` = 030405…12, `ir_eip` = 3, `count` = 29, `fill_ready` = 0.
   - A fill offered in this state is not accepted and `count` is unchanged.
3. **Simultaneous consume and fill.** `count` = 16 with `buf` = 00..0F. Consume `dec_len` = 5 and fill line 20..2F, offset 0, on the same edge.
   - `count` = 27, `ir` = 05..0F,20..24.
4. **Flush with offset.** Flush with `flush_eip` = 0x0000_100A; in the same cycle assert a fill and `dec_accept`.
   - Both are ignored; `ir_valid` = 0 and `ir_eip` = 0x100A.
   - Then fill a line with offset 10: `count` = 6 and `ir_valid` = 0.
   - A next line with offset 0 gives `count` = 22 and `ir` byte 0 = line byte 10.
5. **EIP wrap and zero-length consume.** Flush with `flush_eip` = 0xFFFF_FFFE and offset 14, fill 2 lines, consume `dec_len` = 4.
   - `ir_eip` = 0x0000_0002.
   - `dec_len` = 0 with accept changes nothing.
6. **Asynchronous reset mid-stream.** Assert `reset` mid-cycle with `count` = 24.
   - `ir_valid`, `count` and `ir_eip` drop to 0 before the next edge, and `fill_ready` = 1.
